// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: opcodes, format
// and error codes, FSM states and immediate range helpers.
package instr_encoder_loader_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_SB  = 3'd2,
        FMT_R   = 3'd3,
        FMT_BAD = 3'd4
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2,
        ERR_FULL   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        fmt_e fmt;
        case (opcode)
            OP_IMM, OP_LOAD: fmt = FMT_I;
            OP_STORE:        fmt = FMT_S;
            OP_BRANCH:       fmt = FMT_SB;
            OP_REG:          fmt = FMT_R;
            default:         fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    // A value fits in N signed bits when every bit above N-2 equals the sign bit.
    function automatic logic fits_s12(input logic [31:0] imm);
        return (imm[31:11] == {21{imm[11]}});
    endfunction

    function automatic logic fits_s13(input logic [31:0] imm);
        return (imm[31:12] == {20{imm[12]}});
    endfunction

endpackage

// File: rtl/instr_encoder_loader_imm_packer.sv
// Combinational packer: decoded fields plus signed immediate in, RV32I word out,
// with opcode-format and immediate-range validity flags.
module instr_encoder_loader_imm_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        fmt_ok,
    output logic        range_ok
);

    fmt_e fmt_s;

    assign fmt_s = decode_fmt(opcode);

    // Bit placement per instruction format, plus legality of the immediate
    always_comb begin
        word     = 32'd0;
        fmt_ok   = 1'b1;
        range_ok = 1'b0;
        case (fmt_s)
            FMT_I: begin
                word     = {imm[11:0], rs1, funct3, rd, opcode};
                range_ok = fits_s12(imm);
            end
            FMT_S: begin
                word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                range_ok = fits_s12(imm);
            end
            FMT_SB: begin
                word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                range_ok = fits_s13(imm) && (imm[0] == 1'b0);
            end
            FMT_R: begin
                word     = {funct7, rs2, rs1, funct3, rd, opcode};
                range_ok = 1'b1;
            end
            default: begin
                word     = 32'd0;
                fmt_ok   = 1'b0;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes decoded instruction bundles into RV32I words and writes them into
// IMEM at consecutive addresses, one word every two cycles.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    state_e            state_r, state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   count_r;
    logic [31:0]       wdata_r;
    logic              last_r;
    err_code_e         err_code_r;
    logic              in_ready_r, mem_we_r, busy_r, done_r, err_r;
    logic              in_ready_s, mem_we_s, busy_s, done_s, err_s;
    logic [31:0]       word_s;
    logic              fmt_ok_s, range_ok_s;

    instr_encoder_loader_imm_packer u_packer (
        .opcode   (in_opcode),
        .funct3   (in_funct3),
        .funct7   (in_funct7),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (word_s),
        .fmt_ok   (fmt_ok_s),
        .range_ok (range_ok_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a full IMEM is only detected after the word lands
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_s = ST_LOAD;
                else       state_s = state_r;
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (!fmt_ok_s || !range_ok_s) state_s = ST_ERR;
                    else                          state_s = ST_WRITE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (last_r)                  state_s = ST_DONE;
                else if (addr_r == ADDR_MAX) state_s = ST_ERR;
                else                         state_s = ST_LOAD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flags can be registered
    always_comb begin
        in_ready_s = 1'b0;
        mem_we_s   = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        case (state_s)
            ST_IDLE:  ;
            ST_LOAD:  begin in_ready_s = 1'b1; busy_s = 1'b1; end
            ST_WRITE: begin mem_we_s = 1'b1; busy_s = 1'b1; end
            ST_DONE:  done_s = 1'b1;
            ST_ERR:   err_s  = 1'b1;
            default:  ;
        endcase
    end

    // Registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            mem_we_r   <= mem_we_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
        end
    end

    // Address, data, count and error-code datapath; err_code only moves from NONE
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r     <= ADDR_BASE;
            count_r    <= '0;
            wdata_r    <= 32'd0;
            last_r     <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        addr_r     <= ADDR_BASE;
                        count_r    <= '0;
                        err_code_r <= ERR_NONE;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (!fmt_ok_s) begin
                            err_code_r <= ERR_OPCODE;
                        end else if (!range_ok_s) begin
                            err_code_r <= ERR_RANGE;
                        end else begin
                            wdata_r <= word_s;
                            last_r  <= in_last;
                        end
                    end
                end
                ST_WRITE: begin
                    addr_r  <= addr_r + ADDR_W'(1);
                    count_r <= count_r + (ADDR_W + 1)'(1);
                    if (!last_r && (addr_r == ADDR_MAX)) err_code_r <= ERR_FULL;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_code   = err_code_r;
    assign word_count = count_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed cases plus randomized load sessions checked
// against an arithmetic RV32I encoding model; a small-IMEM instance covers overflow.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset, start, start2, in_valid, in_last;
    logic [6:0]  in_opcode, in_funct7;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        in_ready, mem_we, busy, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    logic        s_in_ready, s_mem_we, s_busy, s_done, s_err;
    logic [1:0]  s_mem_addr, s_err_code;
    logic [31:0] s_mem_wdata;
    logic [2:0]  s_word_count;

    int checks = 0;
    int errors = 0;
    int exp_addr, exp_count;
    int outcome;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_last(in_last), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .busy(s_busy),
        .done(s_done), .err(s_err), .err_code(s_err_code), .word_count(s_word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0 = legal, 1 = unknown opcode, 2 = immediate out of range
    function automatic int model_class(input logic [6:0] op, input logic [31:0] imm);
        int si;
        si = $signed(imm);
        case (op)
            7'h13, 7'h03, 7'h23: return (si >= -2048 && si <= 2047) ? 0 : 2;
            7'h63:               return (si >= -4096 && si <= 4094 && (si % 2) == 0) ? 0 : 2;
            7'h33:               return 0;
            default:             return 1;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input logic [6:0] op, input logic [2:0] f3,
            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] base, i;
        i    = imm;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        case (op)
            7'h13, 7'h03: return base | ((i & 32'hFFF) << 20) | (32'(rd) << 7);
            7'h23: return base | (((i >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((i & 32'h1F) << 7);
            7'h63: return base | (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25)
                        | (32'(rs2) << 20) | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7);
            default: return base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
        endcase
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); @(negedge clk); start = 1'b0;
        exp_addr = 0; exp_count = 0;
        check("start_ready", in_ready, 1);
        check("start_err", err, 0);
        check("start_done", done, 0);
        check("start_addr", mem_addr, 0);
        check("start_count", word_count, 0);
    endtask

    // Present one bundle to the main instance and check the write or the error
    task automatic run_bundle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [31:0] imm, input logic last);
        int cls, n;
        cls = model_class(op, imm);
        @(negedge clk);
        in_opcode = op; in_funct3 = f3; in_funct7 = f7; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 8) begin @(negedge clk); n++; end
        if (!in_ready) begin
            check("ready_timeout", 0, 1);
            in_valid = 1'b0;
            outcome = -1;
            return;
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        if (cls == 0) begin
            check("we", mem_we, 1);
            check("addr", mem_addr, exp_addr);
            check("wdata", mem_wdata, model_word(op, f3, f7, rd, rs1, rs2, imm));
            check("ready_in_write", in_ready, 0);
            @(posedge clk); @(negedge clk);
            exp_addr = (exp_addr + 1) % 256;
            exp_count++;
            check("we_single", mem_we, 0);
            check("count", word_count, exp_count);
            check("next_addr", mem_addr, exp_addr);
            check("done", done, last);
            check("ready_after", in_ready, !last);
            outcome = last ? 1 : 0;
        end else begin
            check("err_we", mem_we, 0);
            check("err_flag", err, 1);
            check("err_code", err_code, cls);
            check("err_busy", busy, 0);
            check("err_count", word_count, exp_count);
            outcome = 2;
        end
    endtask

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op;
        int si, nb;
        ops[0] = 7'h13; ops[1] = 7'h03; ops[2] = 7'h23;
        ops[3] = 7'h63; ops[4] = 7'h33; ops[5] = 7'h37;

        reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_rd = 5'd0;
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        exp_addr = 0; exp_count = 0; outcome = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_count", word_count, 0);

        // Overflow on the 4-word instance; main instance stays idle throughout
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); @(negedge clk); start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0;
            in_imm = 32'(i); in_last = 1'b0; in_valid = 1'b1;
            check("full_ready", s_in_ready, 1);
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            check("full_we", s_mem_we, 1);
            check("full_addr", s_mem_addr, i);
            check("full_wdata", s_mem_wdata, model_word(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i)));
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b1;
        repeat (3) begin
            check("full_err", s_err, 1);
            check("full_code", s_err_code, 3);
            check("full_ready_low", s_in_ready, 0);
            check("full_no_we", s_mem_we, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_count", s_word_count, 4);
        check("main_idle_no_we", mem_we, 0);

        // addi x1,x0,5 ; lw x5,-1(x0)
        do_start();
        run_bundle(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        check("ex1_w0", mem_wdata, 32'h00500093);
        run_bundle(7'h03, 3'd2, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
        check("ex1_w1", mem_wdata, 32'hFFF02283);
        check("ex1_count", word_count, 2);

        // sw x2,8(x0) ; beq x0,x0,-4 ; add x3,x1,x2
        do_start();
        run_bundle(7'h23, 3'd2, 7'd0, 5'd0, 5'd0, 5'd2, 32'd8, 1'b0);
        check("ex2_w0", mem_wdata, 32'h00202423);
        run_bundle(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
        check("ex2_w1", mem_wdata, 32'hFE000EE3);
        run_bundle(7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h12345678, 1'b1);
        check("ex2_w2", mem_wdata, 32'h002081B3);

        // Range and opcode errors, then recovery
        do_start();
        run_bundle(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        do_start();
        run_bundle(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0);
        do_start();
        run_bundle(7'h37, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("sticky_code", err_code, 1);
        do_start();
        run_bundle(7'h63, 3'd1, 7'd0, 5'd0, 5'd4, 5'd5, 32'd4094, 1'b0);
        run_bundle(7'h23, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF800, 1'b1);

        // Randomized sessions
        for (int s = 0; s < 12; s++) begin
            do_start();
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                op = ops[$urandom_range(0, 5)];
                case ($urandom_range(0, 7))
                    0:       si = 2048 + $urandom_range(0, 3000);
                    1:       si = -2049 - $urandom_range(0, 3000);
                    2:       si = $urandom_range(0, 8191) - 4096;
                    default: si = (op == 7'h63) ? ($urandom_range(0, 4095) * 2 - 4096)
                                                : ($urandom_range(0, 4095) - 2048);
                endcase
                run_bundle(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                           5'($urandom), 32'(si), b == nb - 1);
                if (outcome != 0) break;
            end
        end

        // Reset in the cycle after an accept cancels the write strobe
        do_start();
        @(negedge clk);
        in_opcode = 7'h13; in_imm = 32'd7; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        check("pre_rst_we", mem_we, 1);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", word_count, 0);
        repeat (4) begin
            @(negedge clk);
            check("idle_no_ready", in_ready, 0);
            check("idle_no_we", mem_we, 0);
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
